// File: rtl/pad_input_filter.sv
// Purpose : per-pad input conditioning (synchronizer, debounce filter, edge detect, sticky IRQ).
// Latency : pad_in -> filtered_out in SYNC_STAGES + L + 1 edges; pulses combinational; irq_out combinational.
// Backpress: none; a pure streaming stage that samples every cycle and never stalls.
//
// Ports:
//   clk_in, reset_int       single clock, asynchronous active-low reset
//   enable_in               global filter/IRQ enable (synchronizer always runs)
//   pad_in                  raw asynchronous TO_CORE levels from the IO cells
//   dir_cfg_in              per-pad cfg[0]: 1 = input mode, 0 = output mode
//   filter_len_in           debounce length L shared by all pads
//   edge_sel_in             per pad {fall, rise} status select
//   irq_mask_in             per-pad mask into irq_out
//   irq_clear_in            per-pad write-1-to-clear of status
//   filtered_out            debounced levels
//   rise_pulse_out          one-cycle pulse on filtered 0->1
//   fall_pulse_out          one-cycle pulse on filtered 1->0
//   irq_status_out          sticky edge status
//   irq_out                 OR of masked status
module pad_input_filter #(
  parameter int N_PADS      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                  clk_in,
  input  logic                  reset_int,
  input  logic                  enable_in,
  input  logic [N_PADS-1:0]     pad_in,
  input  logic [N_PADS-1:0]     dir_cfg_in,
  input  logic [CNT_WIDTH-1:0]  filter_len_in,
  input  logic [2*N_PADS-1:0]   edge_sel_in,
  input  logic [N_PADS-1:0]     irq_mask_in,
  input  logic [N_PADS-1:0]     irq_clear_in,
  output logic [N_PADS-1:0]     filtered_out,
  output logic [N_PADS-1:0]     rise_pulse_out,
  output logic [N_PADS-1:0]     fall_pulse_out,
  output logic [N_PADS-1:0]     irq_status_out,
  output logic                  irq_out
);

  // ---------------------------------------------------------------------------
  // Synchronizer: stage 0 captures the asynchronous pad, the last stage is the
  // first value the rest of the logic is allowed to look at.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][N_PADS-1:0] sync_q;
  logic [N_PADS-1:0]                  sync_lvl;

  always_ff @(posedge clk_in or negedge reset_int) begin
    if (!reset_int) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_in};
    end
  end

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Debounce filter state
  // ---------------------------------------------------------------------------
  logic [N_PADS-1:0]                filt_q,   filt_d;
  logic [N_PADS-1:0][CNT_WIDTH-1:0] cnt_q,    cnt_d;
  logic [N_PADS-1:0]                prev_q;   // filtered level one cycle ago
  logic [N_PADS-1:0]                dir_q;    // dir_cfg_in one cycle ago
  logic [N_PADS-1:0]                status_q, status_d;

  // The counter tracks how many consecutive edges the synchronized level has
  // disagreed with the filtered level. The compare against L is done with the
  // live filter_len_in, so lowering L mid-count releases on the next mismatch.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < N_PADS; i++) begin
      if (!dir_cfg_in[i]) begin
        // Output mode: the pad reads 0, so forget everything and restart from 0.
        filt_d[i] = 1'b0;
        cnt_d[i]  = '0;
      end else if (!enable_in) begin
        cnt_d[i]  = '0;
      end else if (sync_lvl[i] == filt_q[i]) begin
        cnt_d[i]  = '0;
      end else if (cnt_q[i] >= filter_len_in) begin
        filt_d[i] = sync_lvl[i];
        cnt_d[i]  = '0;
      end else if (cnt_q[i] != '1) begin
        cnt_d[i]  = cnt_q[i] + CNT_WIDTH'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Edge pulses: a filtered transition is only reported when the pad has been
  // in input mode both now and in the previous cycle, so the forced clear on a
  // switch to output mode (or a one-cycle dir blip) never looks like an edge.
  // ---------------------------------------------------------------------------
  logic [N_PADS-1:0] edge_ok;
  logic [N_PADS-1:0] rise_w;
  logic [N_PADS-1:0] fall_w;
  logic [N_PADS-1:0] set_w;

  assign edge_ok = dir_cfg_in & dir_q & {N_PADS{enable_in}};
  assign rise_w  =  filt_q & ~prev_q & edge_ok;
  assign fall_w  = ~filt_q &  prev_q & edge_ok;

  // Status: set has priority over a coincident clear so no edge is ever lost.
  always_comb begin
    set_w = '0;
    for (int i = 0; i < N_PADS; i++) begin
      set_w[i] = (rise_w[i] & edge_sel_in[2*i]) | (fall_w[i] & edge_sel_in[2*i+1]);
    end
    status_d = (status_q & ~irq_clear_in) | set_w;
  end

  always_ff @(posedge clk_in or negedge reset_int) begin
    if (!reset_int) begin
      filt_q   <= '0;
      cnt_q    <= '0;
      prev_q   <= '0;
      dir_q    <= '0;
      status_q <= '0;
    end else begin
      filt_q   <= filt_d;
      cnt_q    <= cnt_d;
      prev_q   <= filt_q;
      dir_q    <= dir_cfg_in;
      status_q <= status_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign filtered_out   = filt_q;
  assign rise_pulse_out = rise_w;
  assign fall_pulse_out = fall_w;
  assign irq_status_out = status_q;
  assign irq_out        = |(status_q & irq_mask_in);

endmodule

// File: tb/tb_pad_input_filter.sv
module tb_pad_input_filter;

  localparam int N  = 8;
  localparam int S  = 2;
  localparam int CW = 8;

  logic            clk_in = 1'b0;
  logic            reset_int;
  logic            enable_in;
  logic [N-1:0]    pad_in;
  logic [N-1:0]    dir_cfg_in;
  logic [CW-1:0]   filter_len_in;
  logic [2*N-1:0]  edge_sel_in;
  logic [N-1:0]    irq_mask_in;
  logic [N-1:0]    irq_clear_in;
  logic [N-1:0]    filtered_out;
  logic [N-1:0]    rise_pulse_out;
  logic [N-1:0]    fall_pulse_out;
  logic [N-1:0]    irq_status_out;
  logic            irq_out;

  int n_checks = 0;
  int n_errors = 0;

  pad_input_filter #(.N_PADS(N), .SYNC_STAGES(S), .CNT_WIDTH(CW)) dut (
    .clk_in         (clk_in),
    .reset_int      (reset_int),
    .enable_in      (enable_in),
    .pad_in         (pad_in),
    .dir_cfg_in     (dir_cfg_in),
    .filter_len_in  (filter_len_in),
    .edge_sel_in    (edge_sel_in),
    .irq_mask_in    (irq_mask_in),
    .irq_clear_in   (irq_clear_in),
    .filtered_out   (filtered_out),
    .rise_pulse_out (rise_pulse_out),
    .fall_pulse_out (fall_pulse_out),
    .irq_status_out (irq_status_out),
    .irq_out        (irq_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Reference model: pad delayed through an S-deep sample queue; a pad's
  // filtered level flips once the delayed level has disagreed with it for
  // L+1 consecutive edges (run length kept as a plain integer).
  // ---------------------------------------------------------------------------
  logic [N-1:0] m_pipe[$];
  logic [N-1:0] m_filt, m_prev, m_dir_q, m_status;
  int           m_run[N];

  function automatic logic [N-1:0] m_rise();
    return m_filt & ~m_prev & dir_cfg_in & m_dir_q & {N{enable_in}};
  endfunction

  function automatic logic [N-1:0] m_fall();
    return ~m_filt & m_prev & dir_cfg_in & m_dir_q & {N{enable_in}};
  endfunction

  task automatic model_reset();
    m_filt = '0; m_prev = '0; m_dir_q = '0; m_status = '0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
    m_pipe.delete();
    for (int k = 0; k < S; k++) m_pipe.push_back('0);
  endtask

  task automatic model_edge();
    logic [N-1:0] r, f, st, s;
    r = m_rise();
    f = m_fall();
    st = '0;
    for (int i = 0; i < N; i++) st[i] = (r[i] & edge_sel_in[2*i]) | (f[i] & edge_sel_in[2*i+1]);
    m_status = (m_status & ~irq_clear_in) | st;
    m_prev  = m_filt;
    m_dir_q = dir_cfg_in;
    s = m_pipe[0];
    for (int i = 0; i < N; i++) begin
      if (!dir_cfg_in[i]) begin
        m_filt[i] = 1'b0; m_run[i] = 0;
      end else if (!enable_in || s[i] == m_filt[i]) begin
        m_run[i] = 0;
      end else if (m_run[i] >= int'(filter_len_in)) begin
        m_filt[i] = s[i]; m_run[i] = 0;
      end else begin
        m_run[i] = m_run[i] + 1;
      end
    end
    void'(m_pipe.pop_front());
    m_pipe.push_back(pad_in);
  endtask

  // One clock: model advances at the rising edge, control returns at the
  // falling edge where outputs are sampled and new inputs are driven.
  task automatic tick();
    @(posedge clk_in);
    if (!reset_int) model_reset();
    else            model_edge();
    @(negedge clk_in);
  endtask

  task automatic settle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic clear_status();
    irq_clear_in = '1;
    tick();
    irq_clear_in = '0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset_int = 1'b0; enable_in = 1'b1; dir_cfg_in = '1; filter_len_in = 8'd3;
    edge_sel_in = '1; irq_mask_in = '1; irq_clear_in = '0; pad_in = '1;
    settle(3);
    n_checks++; if (filtered_out !== '0) begin n_errors++; $display("FAIL reset_filtered: got %h expected 00", filtered_out); end
    n_checks++; if (rise_pulse_out !== '0) begin n_errors++; $display("FAIL reset_rise: got %h expected 00", rise_pulse_out); end
    n_checks++; if (fall_pulse_out !== '0) begin n_errors++; $display("FAIL reset_fall: got %h expected 00", fall_pulse_out); end
    n_checks++; if (irq_status_out !== '0) begin n_errors++; $display("FAIL reset_status: got %h expected 00", irq_status_out); end
    n_checks++; if (irq_out !== 1'b0) begin n_errors++; $display("FAIL reset_irq: got %b expected 0", irq_out); end
    pad_in = '0; irq_mask_in = '0; edge_sel_in = '0;
    reset_int = 1'b1;
    settle(8);
  endtask

  task automatic test_latency();
    int lat; logic p_at, p_after;
    lat = -1; p_at = 1'b0; p_after = 1'b1;
    filter_len_in = 8'd3;
    pad_in[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (lat > 0 && k == lat + 1) p_after = rise_pulse_out[0];
      if (lat < 0 && filtered_out[0]) begin lat = k; p_at = rise_pulse_out[0]; end
    end
    n_checks++; if (lat != 6) begin n_errors++; $display("FAIL latency_L3: got %0d edges expected 6", lat); end
    n_checks++; if (p_at !== 1'b1) begin n_errors++; $display("FAIL latency_pulse_on: got %b expected 1", p_at); end
    n_checks++; if (p_after !== 1'b0) begin n_errors++; $display("FAIL latency_pulse_off: got %b expected 0", p_after); end
  endtask

  task automatic test_glitch();
    logic any_f, any_p; int lat;
    filter_len_in = 8'd3; edge_sel_in[3:2] = 2'b11;
    any_f = 1'b0; any_p = 1'b0;
    pad_in[1] = 1'b1;
    settle(3);
    pad_in[1] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      any_f |= filtered_out[1];
      any_p |= rise_pulse_out[1] | fall_pulse_out[1];
    end
    n_checks++; if (any_f !== 1'b0) begin n_errors++; $display("FAIL glitch3_filtered: got %b expected 0", any_f); end
    n_checks++; if (any_p !== 1'b0) begin n_errors++; $display("FAIL glitch3_pulse: got %b expected 0", any_p); end
    n_checks++; if (irq_status_out[1] !== 1'b0) begin n_errors++; $display("FAIL glitch3_status: got %b expected 0", irq_status_out[1]); end
    lat = -1;
    pad_in[1] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      if (k == 5) pad_in[1] = 1'b0;
      tick();
      if (lat < 0 && filtered_out[1]) lat = k;
    end
    n_checks++; if (lat != 6) begin n_errors++; $display("FAIL glitch4_rise: got %0d edges expected 6", lat); end
    n_checks++; if (irq_status_out[1] !== 1'b1) begin n_errors++; $display("FAIL glitch4_status: got %b expected 1", irq_status_out[1]); end
    edge_sel_in[3:2] = 2'b00;
    clear_status();
    settle(4);
  endtask

  task automatic test_bypass();
    int lat, nr, nf;
    filter_len_in = 8'd0; nr = 0; nf = 0;
    for (int t = 0; t < 4; t++) begin
      pad_in[2] = ~pad_in[2];
      lat = -1;
      for (int k = 1; k <= 4; k++) begin
        tick();
        if (lat < 0 && filtered_out[2] == pad_in[2]) lat = k;
        nr += int'(rise_pulse_out[2]);
        nf += int'(fall_pulse_out[2]);
      end
      n_checks++; if (lat != 3) begin n_errors++; $display("FAIL bypass_latency t%0d: got %0d expected 3", t, lat); end
    end
    n_checks++; if (nr != 2 || nf != 2) begin n_errors++; $display("FAIL bypass_pulses: got rise %0d fall %0d expected 2 2", nr, nf); end
    filter_len_in = 8'd3;
    settle(4);
  endtask

  task automatic test_irq();
    logic any_st, found;
    edge_sel_in[7:6] = 2'b10; irq_mask_in = 8'h08;
    any_st = 1'b0;
    pad_in[3] = 1'b1;
    for (int k = 0; k < 10; k++) begin tick(); any_st |= irq_status_out[3] | irq_out; end
    n_checks++; if (filtered_out[3] !== 1'b1 || any_st !== 1'b0) begin n_errors++; $display("FAIL irq_rise_ignored: got filt %b st %b expected 1 0", filtered_out[3], any_st); end
    pad_in[3] = 1'b0; found = 1'b0;
    for (int k = 0; k < 15 && !found; k++) begin tick(); found = fall_pulse_out[3]; end
    n_checks++; if (!found || irq_status_out[3] !== 1'b0) begin n_errors++; $display("FAIL irq_fall_pulse: got found %b st %b expected 1 0", found, irq_status_out[3]); end
    tick();
    n_checks++; if (irq_status_out[3] !== 1'b1) begin n_errors++; $display("FAIL irq_status_set: got %b expected 1", irq_status_out[3]); end
    n_checks++; if (irq_out !== 1'b1) begin n_errors++; $display("FAIL irq_out_set: got %b expected 1", irq_out); end
    irq_mask_in[3] = 1'b0; #1;
    n_checks++; if (irq_out !== 1'b0) begin n_errors++; $display("FAIL irq_masked: got %b expected 0", irq_out); end
    irq_mask_in[3] = 1'b1; #1;
    n_checks++; if (irq_out !== 1'b1) begin n_errors++; $display("FAIL irq_unmask_same_cycle: got %b expected 1", irq_out); end
    pad_in[3] = 1'b1;
    settle(10);
    pad_in[3] = 1'b0; found = 1'b0;
    for (int k = 0; k < 15 && !found; k++) begin tick(); found = fall_pulse_out[3]; end
    irq_clear_in[3] = 1'b1;
    tick();
    irq_clear_in[3] = 1'b0;
    n_checks++; if (!found || irq_status_out[3] !== 1'b1) begin n_errors++; $display("FAIL irq_set_beats_clear: got found %b st %b expected 1 1", found, irq_status_out[3]); end
    irq_clear_in[3] = 1'b1;
    tick();
    irq_clear_in[3] = 1'b0;
    n_checks++; if (irq_status_out[3] !== 1'b0 || irq_out !== 1'b0) begin n_errors++; $display("FAIL irq_clear: got st %b irq %b expected 0 0", irq_status_out[3], irq_out); end
    edge_sel_in[7:6] = 2'b00; irq_mask_in = '0;
  endtask

  task automatic test_dir_enable();
    logic [N-1:0] f_snap, s_snap;
    logic bad_f, bad_p, bad_s;
    edge_sel_in[9:8] = 2'b11;
    pad_in[4] = 1'b1;
    settle(10);
    clear_status();
    n_checks++; if (filtered_out[4] !== 1'b1 || irq_status_out[4] !== 1'b0) begin n_errors++; $display("FAIL dir_setup: got filt %b st %b expected 1 0", filtered_out[4], irq_status_out[4]); end
    dir_cfg_in[4] = 1'b0;
    tick();
    n_checks++; if (filtered_out[4] !== 1'b0 || fall_pulse_out[4] !== 1'b0) begin n_errors++; $display("FAIL dir_off_clear: got filt %b fall %b expected 0 0", filtered_out[4], fall_pulse_out[4]); end
    tick();
    n_checks++; if (irq_status_out[4] !== 1'b0) begin n_errors++; $display("FAIL dir_off_status: got %b expected 0", irq_status_out[4]); end
    dir_cfg_in[4] = 1'b1;
    settle(10);
    edge_sel_in = '1;
    clear_status();
    f_snap = filtered_out; s_snap = irq_status_out;
    bad_f = 1'b0; bad_p = 1'b0; bad_s = 1'b0;
    enable_in = 1'b0;
    for (int k = 0; k < 20; k++) begin
      pad_in = N'($urandom);
      tick();
      bad_f |= (filtered_out !== f_snap);
      bad_p |= (rise_pulse_out !== '0) || (fall_pulse_out !== '0);
      bad_s |= (irq_status_out !== s_snap);
    end
    n_checks++; if (bad_f) begin n_errors++; $display("FAIL enable_off_filtered: got %h expected held %h", filtered_out, f_snap); end
    n_checks++; if (bad_p) begin n_errors++; $display("FAIL enable_off_pulses: got rise %h fall %h expected 00", rise_pulse_out, fall_pulse_out); end
    n_checks++; if (bad_s) begin n_errors++; $display("FAIL enable_off_status: got %h expected %h", irq_status_out, s_snap); end
    pad_in = f_snap;
    settle(3);
    enable_in = 1'b1;
    edge_sel_in = '0;
    settle(6);
  endtask

  task automatic test_async_reset();
    filter_len_in = 8'd5; irq_mask_in = '1; edge_sel_in = '0; edge_sel_in[11:10] = 2'b01;
    clear_status();
    pad_in[5] = 1'b1;
    settle(12);
    pad_in[6] = 1'b1;
    settle(4);
    n_checks++; if (irq_status_out[5] !== 1'b1 || irq_out !== 1'b1) begin n_errors++; $display("FAIL areset_pre: got st %b irq %b expected 1 1", irq_status_out[5], irq_out); end
    #2 reset_int = 1'b0;
    model_reset();
    #1;
    n_checks++; if (filtered_out !== '0 || rise_pulse_out !== '0 || fall_pulse_out !== '0) begin n_errors++; $display("FAIL areset_levels: got f %h r %h fl %h expected 00", filtered_out, rise_pulse_out, fall_pulse_out); end
    n_checks++; if (irq_status_out !== '0 || irq_out !== 1'b0) begin n_errors++; $display("FAIL areset_irq: got st %h irq %b expected 00 0", irq_status_out, irq_out); end
    tick();
    reset_int = 1'b1;
    settle(12);
    n_checks++; if (filtered_out[6:5] !== 2'b11) begin n_errors++; $display("FAIL areset_recover: got %b expected 11", filtered_out[6:5]); end
  endtask

  task automatic test_random();
    int idx;
    reset_int = 1'b0; pad_in = '0; irq_clear_in = '0;
    settle(2);
    reset_int = 1'b1;
    enable_in = 1'b1; dir_cfg_in = '1; filter_len_in = 8'd2;
    edge_sel_in = 16'($urandom); irq_mask_in = N'($urandom);
    for (int c = 0; c < 3000; c++) begin
      tick();
      n_checks++; if (filtered_out !== m_filt) begin n_errors++; if (n_errors < 20) $display("FAIL rnd_filtered c%0d: got %h expected %h", c, filtered_out, m_filt); end
      n_checks++; if (rise_pulse_out !== m_rise()) begin n_errors++; if (n_errors < 20) $display("FAIL rnd_rise c%0d: got %h expected %h", c, rise_pulse_out, m_rise()); end
      n_checks++; if (fall_pulse_out !== m_fall()) begin n_errors++; if (n_errors < 20) $display("FAIL rnd_fall c%0d: got %h expected %h", c, fall_pulse_out, m_fall()); end
      n_checks++; if (irq_status_out !== m_status) begin n_errors++; if (n_errors < 20) $display("FAIL rnd_status c%0d: got %h expected %h", c, irq_status_out, m_status); end
      n_checks++; if (irq_out !== |(m_status & irq_mask_in)) begin n_errors++; if (n_errors < 20) $display("FAIL rnd_irq c%0d: got %b expected %b", c, irq_out, |(m_status & irq_mask_in)); end
      for (int i = 0; i < N; i++) if ($urandom_range(0, 5) == 0) pad_in[i] = ~pad_in[i];
      if ($urandom_range(0, 99) == 0) filter_len_in = CW'($urandom_range(0, 6));
      if ($urandom_range(0, 49) == 0) begin idx = $urandom_range(0, N-1); dir_cfg_in[idx] = ~dir_cfg_in[idx]; end
      if ($urandom_range(0, 59) == 0) enable_in = ~enable_in;
      if ($urandom_range(0, 199) == 0) edge_sel_in = 16'($urandom);
      if ($urandom_range(0, 49) == 0) irq_mask_in = N'($urandom);
      irq_clear_in = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
    end
    irq_clear_in = '0; enable_in = 1'b1; dir_cfg_in = '1;
  endtask

  initial begin
    reset_int = 1'b0; enable_in = 1'b1; pad_in = '0; dir_cfg_in = '1;
    filter_len_in = 8'd3; edge_sel_in = '0; irq_mask_in = '0; irq_clear_in = '0;
    test_reset();
    test_latency();
    test_glitch();
    test_bypass();
    test_irq();
    test_dir_enable();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
